// File: rtl/bus_pkg.sv
// Shared types for the memory bus arbiter.
//   arb_state_t : arbiter FSM states
//   grant_src_t : which requester owns the bus
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      INSTR = 2'd1,
      DATA  = 2'd2,
      DRAIN = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_INSTR = 1'b0,
      GRANT_DATA  = 1'b1
   } grant_src_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported memory bus between the fetch
// port and the data port with round-robin arbitration. A granted request is
// held on the mem_* side until mem_rsp_i; the response is steered back to
// its owner. A fetch flushed while in flight is drained and its response
// discarded.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   instr_flush_i              cancel pending / in-flight fetch
//   instr_req_i, instr_addr_i  fetch request (level) and address
//   instr_rsp_o, instr_data_o  fetch response pulse and data
//   data_mem_rd_i/_wr_i        data read / write request (level)
//   data_addr_i, data_write_i  data address and write data
//   data_mem_rsp_o, data_read_o data response pulse and read data
//   mem_rd_o, mem_wr_o         memory read / write request (level, registered)
//   mem_addr_o, mem_write_data_o memory address / write data (registered)
//   mem_rsp_i, mem_read_data_i memory response pulse and read data
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | bus free; arbitrate between pending requests
// INSTR | fetch issued, waiting for memory response
// DATA  | data read/write issued, waiting for memory response
// DRAIN | flushed fetch in flight; response will be discarded
module mem_bus_arbiter
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_flush_i,
   input  logic                  instr_req_i,
   input  logic [ADDR_WIDTH-1:0] instr_addr_i,
   output logic                  instr_rsp_o,
   output logic [DATA_WIDTH-1:0] instr_data_o,
   input  logic                  data_mem_rd_i,
   input  logic                  data_mem_wr_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic [DATA_WIDTH-1:0] data_write_i,
   output logic                  data_mem_rsp_o,
   output logic [DATA_WIDTH-1:0] data_read_o,
   output logic                  mem_rd_o,
   output logic                  mem_wr_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_write_data_o,
   input  logic                  mem_rsp_i,
   input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

   arb_state_t state_q, state_d;
   grant_src_t last_grant_q;
   logic       data_pend;
   logic       instr_pend;
   logic       grant_data;
   logic       grant_instr;

   assign instr_data_o = mem_read_data_i;
   assign data_read_o  = mem_read_data_i;

   always_comb begin
      data_pend   = data_mem_rd_i | data_mem_wr_i;
      instr_pend  = instr_req_i & ~instr_flush_i;
      // On a tie the side that did not win last time gets the bus.
      grant_data  = data_pend & (~instr_pend | (last_grant_q == GRANT_INSTR));
      grant_instr = instr_pend & ~grant_data;

      state_d        = state_q;
      instr_rsp_o    = 1'b0;
      data_mem_rsp_o = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_data) begin
               state_d = DATA;
            end else if (grant_instr) begin
               state_d = INSTR;
            end
         end
         INSTR: begin
            if (mem_rsp_i) begin
               state_d     = IDLE;
               instr_rsp_o = ~instr_flush_i;
            end else if (instr_flush_i) begin
               state_d = DRAIN;
            end
         end
         DATA: begin
            if (mem_rsp_i) begin
               state_d        = IDLE;
               data_mem_rsp_o = 1'b1;
            end
         end
         DRAIN: begin
            if (mem_rsp_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         last_grant_q     <= GRANT_INSTR;
         mem_rd_o         <= 1'b0;
         mem_wr_o         <= 1'b0;
         mem_addr_o       <= '0;
         mem_write_data_o <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            if (grant_data) begin
               // rd and wr together resolve to a write.
               mem_rd_o         <= data_mem_rd_i & ~data_mem_wr_i;
               mem_wr_o         <= data_mem_wr_i;
               mem_addr_o       <= data_addr_i;
               mem_write_data_o <= data_write_i;
               last_grant_q     <= GRANT_DATA;
            end else if (grant_instr) begin
               mem_rd_o         <= 1'b1;
               mem_wr_o         <= 1'b0;
               mem_addr_o       <= instr_addr_i;
               mem_write_data_o <= '0;
               last_grant_q     <= GRANT_INSTR;
            end
         end else if (mem_rsp_i) begin
            mem_rd_o         <= 1'b0;
            mem_wr_o         <= 1'b0;
            mem_addr_o       <= '0;
            mem_write_data_o <= '0;
         end
      end
   end

   a_data_rd_wr_exclusive : assert property (
      @(posedge clk) disable iff (!rst_n) !(data_mem_rd_i && data_mem_wr_i));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_flush_i = 1'b0;
   logic        instr_req_i = 1'b0;
   logic [31:0] instr_addr_i = '0;
   logic        instr_rsp_o;
   logic [31:0] instr_data_o;
   logic        data_mem_rd_i = 1'b0;
   logic        data_mem_wr_i = 1'b0;
   logic [31:0] data_addr_i = '0;
   logic [31:0] data_write_i = '0;
   logic        data_mem_rsp_o;
   logic [31:0] data_read_o;
   logic        mem_rd_o;
   logic        mem_wr_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_write_data_o;
   logic        mem_rsp_i = 1'b0;
   logic [31:0] mem_read_data_i = '0;

   mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .instr_flush_i    (instr_flush_i),
      .instr_req_i      (instr_req_i),
      .instr_addr_i     (instr_addr_i),
      .instr_rsp_o      (instr_rsp_o),
      .instr_data_o     (instr_data_o),
      .data_mem_rd_i    (data_mem_rd_i),
      .data_mem_wr_i    (data_mem_wr_i),
      .data_addr_i      (data_addr_i),
      .data_write_i     (data_write_i),
      .data_mem_rsp_o   (data_mem_rsp_o),
      .data_read_o      (data_read_o),
      .mem_rd_o         (mem_rd_o),
      .mem_wr_o         (mem_wr_o),
      .mem_addr_o       (mem_addr_o),
      .mem_write_data_o (mem_write_data_o),
      .mem_rsp_i        (mem_rsp_i),
      .mem_read_data_i  (mem_read_data_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } req_t;

   typedef struct {
      bit          is_d;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          start;
      int          rspc;
   } txn_t;

   typedef struct {
      bit          is_instr;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      bit          flush;
      bit          e_rd;
      bit          e_wr;
      logic [31:0] e_rdata;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mem_lat = 1;
   int mcnt = 0;
   int flush_at = -1;
   bit h_rd, h_wr;
   logic [31:0] h_addr, h_wdata;
   req_t i_q[$];
   req_t d_q[$];
   logic [31:0] exp_i[$];
   req_t exp_d[$];
   txn_t tlog[$];
   bit saw_irsp = 1'b0;
   bit saw_drsp = 1'b0;
   logic [31:0] mem_img [logic [31:0]];
   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (mem_img.exists(a)) return mem_img[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic req_t mk(input bit wr, input logic [31:0] a, input logic [31:0] wd);
      req_t r;
      r.wr = wr;
      r.addr = a;
      r.wdata = wd;
      r.exp = wr ? 32'h0 : model_read(a);
      return r;
   endfunction

   // One bench cycle: requesters and memory model drive at the falling edge,
   // outputs are sampled 1 time unit later.
   task automatic cycle();
      req_t r;
      txn_t t;
      @(negedge clk);
      cyc++;
      if (saw_irsp) begin instr_req_i = 1'b0; saw_irsp = 1'b0; end
      if (saw_drsp) begin data_mem_rd_i = 1'b0; data_mem_wr_i = 1'b0; saw_drsp = 1'b0; end
      instr_flush_i = 1'b0;
      if (cyc == flush_at) begin
         instr_flush_i = 1'b1;
         if (instr_req_i) begin
            instr_req_i = 1'b0;
            exp_i.delete(exp_i.size() - 1);
         end
      end
      if (!instr_req_i && i_q.size() > 0 && cyc != flush_at) begin
         r = i_q.pop_front();
         instr_addr_i = r.addr;
         instr_req_i = 1'b1;
         exp_i.push_back(r.exp);
      end
      if (!data_mem_rd_i && !data_mem_wr_i && d_q.size() > 0) begin
         r = d_q.pop_front();
         data_addr_i = r.addr;
         data_write_i = r.wdata;
         data_mem_wr_i = r.wr;
         data_mem_rd_i = !r.wr;
         exp_d.push_back(r);
      end
      mem_rsp_i = 1'b0;
      mem_read_data_i = '0;
      if (rst_n && (mem_rd_o || mem_wr_o)) begin
         mcnt++;
         if (mcnt == 1) begin
            h_rd = mem_rd_o; h_wr = mem_wr_o; h_addr = mem_addr_o; h_wdata = mem_write_data_o;
            t.is_d = (mem_addr_o >= 32'h8000);
            t.rd = mem_rd_o; t.wr = mem_wr_o; t.addr = mem_addr_o; t.wdata = mem_write_data_o;
            t.start = cyc; t.rspc = -1;
            tlog.push_back(t);
         end else begin
            chk("hold_mem_rd", 32'(mem_rd_o), 32'(h_rd));
            chk("hold_mem_wr", 32'(mem_wr_o), 32'(h_wr));
            chk("hold_mem_addr", mem_addr_o, h_addr);
            chk("hold_mem_wdata", mem_write_data_o, h_wdata);
         end
         if (mcnt == mem_lat + 1) begin
            mem_rsp_i = 1'b1;
            if (mem_wr_o) mem_img[mem_addr_o] = mem_write_data_o;
            else mem_read_data_i = model_read(mem_addr_o);
            t = tlog.pop_back();
            t.rspc = cyc;
            tlog.push_back(t);
            mcnt = 0;
         end
      end
      #1;
      if (instr_rsp_o) begin
         if (exp_i.size() == 0) chk("instr_rsp_unexpected", 32'(instr_rsp_o), 32'h0);
         else chk("instr_data", instr_data_o, exp_i.pop_front());
         saw_irsp = 1'b1;
      end
      if (data_mem_rsp_o) begin
         if (exp_d.size() == 0) chk("data_rsp_unexpected", 32'(data_mem_rsp_o), 32'h0);
         else begin
            r = exp_d.pop_front();
            if (!r.wr) chk("data_read", data_read_o, r.exp);
            else chk("data_wr_ack", 32'(data_mem_rsp_o), 32'h1);
         end
         saw_drsp = 1'b1;
      end
   endtask

   task automatic run_until_quiet(input int budget, input string name);
      int n = 0;
      bit busy;
      do begin
         cycle();
         n++;
         busy = (i_q.size() > 0) || (d_q.size() > 0) || (exp_i.size() > 0) ||
                (exp_d.size() > 0) || mem_rd_o || mem_wr_o || (mcnt != 0);
      end while (busy && n < budget);
      chk({name, "_quiet"}, 32'(busy), 32'h0);
   endtask

   task automatic wait_start(input int n_exp, input string name);
      int n = 0;
      while (tlog.size() < n_exp && n < 20) begin cycle(); n++; end
      chk({name, "_started"}, 32'(tlog.size()), 32'(n_exp));
   endtask

   initial begin
      int t0, g;
      mem_img[32'h100] = 32'h0000_0013;
      vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 1'b0, 1'b1, 1'b0, 32'h0000_0013};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_8010, 32'hCAFE_F00D, 1, 1'b0, 1'b0, 1'b1, 32'h0};
      vecs[2] = '{1'b0, 1'b0, 32'h0000_8010, 32'h0, 3, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 1'b0, 1'b1, 1'b0, 32'h5A5A_0104};
      vecs[4] = '{1'b0, 1'b0, 32'h0000_8020, 32'h0, 1, 1'b0, 1'b1, 1'b0, 32'h5A5A_8020};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_01F0, 32'h0, 4, 1'b0, 1'b1, 1'b0, 32'h5A5A_01F0};

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_rd", 32'(mem_rd_o), 32'h0);
      chk("rst_mem_wr", 32'(mem_wr_o), 32'h0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_mem_wdata", mem_write_data_o, 32'h0);
      chk("rst_instr_rsp", 32'(instr_rsp_o), 32'h0);
      chk("rst_data_rsp", 32'(data_mem_rsp_o), 32'h0);
      rst_n = 1'b1;

      // first tie after reset: data wins, fetch follows at M+2
      tlog.delete();
      mem_lat = 1;
      i_q.push_back(mk(1'b0, 32'h200, 32'h0));
      d_q.push_back(mk(1'b0, 32'h8000, 32'h0));
      t0 = cyc + 1;
      run_until_quiet(40, "tie");
      chk("tie_count", 32'(tlog.size()), 32'h2);
      if (tlog.size() == 2) begin
         chk("tie_first_is_data", 32'(tlog[0].is_d), 32'h1);
         chk("tie_issue_latency", 32'(tlog[0].start), 32'(t0 + 1));
         chk("tie_second_is_instr", 32'(tlog[1].is_d), 32'h0);
         chk("tie_second_addr", tlog[1].addr, 32'h200);
         chk("tie_back_to_back", 32'(tlog[1].start), 32'(tlog[0].rspc + 2));
      end

      // continuous contention alternates D,I,D,I,D,I
      tlog.delete();
      for (int k = 0; k < 3; k++) begin
         i_q.push_back(mk(1'b0, 32'h400 + 32'(4 * k), 32'h0));
         d_q.push_back(mk(1'b0, 32'h8100 + 32'(4 * k), 32'h0));
      end
      run_until_quiet(80, "rr");
      chk("rr_count", 32'(tlog.size()), 32'h6);
      if (tlog.size() == 6) begin
         for (int k = 0; k < 6; k++) chk($sformatf("rr_order_%0d", k), 32'(tlog[k].is_d), 32'((k % 2) == 0));
      end

      // table of single transactions
      foreach (vecs[k]) begin
         tlog.delete();
         mem_lat = vecs[k].lat;
         if (vecs[k].is_instr) i_q.push_back('{1'b0, vecs[k].addr, 32'h0, vecs[k].e_rdata});
         else d_q.push_back('{vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].e_rdata});
         t0 = cyc + 1;
         if (vecs[k].flush) flush_at = t0 + 2;
         run_until_quiet(40, $sformatf("vec%0d", k));
         flush_at = -1;
         chk($sformatf("vec%0d_count", k), 32'(tlog.size()), 32'h1);
         if (tlog.size() == 1) begin
            chk($sformatf("vec%0d_issue", k), 32'(tlog[0].start), 32'(t0 + 1));
            chk($sformatf("vec%0d_lat", k), 32'(tlog[0].rspc - tlog[0].start), 32'(vecs[k].lat));
            chk($sformatf("vec%0d_rd", k), 32'(tlog[0].rd), 32'(vecs[k].e_rd));
            chk($sformatf("vec%0d_wr", k), 32'(tlog[0].wr), 32'(vecs[k].e_wr));
            chk($sformatf("vec%0d_addr", k), tlog[0].addr, vecs[k].addr);
            if (vecs[k].wr) chk($sformatf("vec%0d_wdata", k), tlog[0].wdata, vecs[k].wdata);
         end
      end

      // flush one cycle after fetch grant: drained, data write follows
      tlog.delete();
      mem_lat = 3;
      i_q.push_back(mk(1'b0, 32'h300, 32'h0));
      wait_start(1, "drain");
      g = (tlog.size() > 0) ? tlog[0].start : cyc;
      d_q.push_back(mk(1'b1, 32'h8004, 32'hDEAD_BEEF));
      flush_at = cyc + 1;
      run_until_quiet(40, "drain");
      flush_at = -1;
      chk("drain_count", 32'(tlog.size()), 32'h2);
      if (tlog.size() == 2) begin
         chk("drain_fetch_rsp_cycle", 32'(tlog[0].rspc), 32'(g + 3));
         chk("drain_write_after", 32'(tlog[1].start), 32'(tlog[0].rspc + 2));
         chk("drain_write_wr", 32'(tlog[1].wr), 32'h1);
         chk("drain_write_addr", tlog[1].addr, 32'h8004);
         chk("drain_write_data", tlog[1].wdata, 32'hDEAD_BEEF);
      end

      // flush coincident with the fetch response
      tlog.delete();
      mem_lat = 2;
      i_q.push_back(mk(1'b0, 32'h500, 32'h0));
      wait_start(1, "coflush");
      g = (tlog.size() > 0) ? tlog[0].start : cyc;
      flush_at = g + 2;
      d_q.push_back(mk(1'b0, 32'h8030, 32'h0));
      run_until_quiet(40, "coflush");
      flush_at = -1;
      chk("coflush_count", 32'(tlog.size()), 32'h2);
      if (tlog.size() == 2) begin
         chk("coflush_rsp_cycle", 32'(tlog[0].rspc), 32'(g + 2));
         chk("coflush_idle_next", 32'(tlog[1].start), 32'(g + 4));
         chk("coflush_next_is_data", 32'(tlog[1].is_d), 32'h1);
      end

      // reset during an in-flight data write
      tlog.delete();
      mem_lat = 5;
      d_q.push_back(mk(1'b1, 32'h8040, 32'h1234_5678));
      wait_start(1, "rstmid");
      chk("rstmid_wr_before", 32'(mem_wr_o), 32'h1);
      #2;
      rst_n = 1'b0;
      data_mem_wr_i = 1'b0;
      data_mem_rd_i = 1'b0;
      #1;
      chk("rstmid_mem_wr", 32'(mem_wr_o), 32'h0);
      chk("rstmid_mem_rd", 32'(mem_rd_o), 32'h0);
      chk("rstmid_mem_addr", mem_addr_o, 32'h0);
      chk("rstmid_mem_wdata", mem_write_data_o, 32'h0);
      chk("rstmid_data_rsp", 32'(data_mem_rsp_o), 32'h0);
      chk("rstmid_instr_rsp", 32'(instr_rsp_o), 32'h0);
      exp_d.delete();
      mcnt = 0;
      saw_drsp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tlog.delete();
      mem_lat = 1;
      i_q.push_back(mk(1'b0, 32'h0, 32'h0));
      t0 = cyc + 1;
      run_until_quiet(40, "postrst");
      chk("postrst_count", 32'(tlog.size()), 32'h1);
      if (tlog.size() == 1) begin
         chk("postrst_issue", 32'(tlog[0].start), 32'(t0 + 1));
         chk("postrst_addr", tlog[0].addr, 32'h0);
         chk("postrst_is_instr", 32'(tlog[0].is_d), 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
